// File: rtl/queue_fifo.sv
// queue_fifo: synchronous FIFO with one-hot read/write pointers, occupancy counter and
// full/empty/overflow/underflow flags. Define QUEUE_FIFO_FWFT_EN for first-word fall-through reads.
module queue_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push_ok_s, pop_ok_s;
  logic [WIDTH-1:0] rd_word_s;

  function automatic logic [DEPTH-1:0] rotl1(input logic [DEPTH-1:0] p);
    return {p[DEPTH-2:0], p[DEPTH-1]};
  endfunction

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == CW'(0));
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Head word: OR of all entries, each gated by its read-pointer bit.
  always_comb begin
    rd_word_s = {WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      rd_word_s = rd_word_s | (mem_q[i] & {WIDTH{rd_ptr_q[i]}});
    end
  end

  // Accept decisions and next-state for pointers, counter and pulse flags.
  always_comb begin
    pop_ok_s    = pop && !empty;
    push_ok_s   = push && (!full || pop_ok_s);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = push && !push_ok_s;
    underflow_d = pop && !pop_ok_s;
    if (push_ok_s) begin
      wr_ptr_d = rotl1(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rotl1(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      wr_ptr_q    <= DEPTH'(1);
      rd_ptr_q    <= DEPTH'(1);
      count_q     <= CW'(0);
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage: only the slot selected by the write pointer is updated on an accepted push.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ptr_q[i]) begin
          mem_q[i] <= data_in;
        end
      end
    end
  end

`ifdef QUEUE_FIFO_FWFT_EN
  assign data_out = empty ? {WIDTH{1'b0}} : rd_word_s;
`else
  logic [WIDTH-1:0] data_out_q;

  // Registered read: the popped head appears one cycle after the pop edge and then holds.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      data_out_q <= {WIDTH{1'b0}};
    end else if (pop_ok_s) begin
      data_out_q <= rd_word_s;
    end else begin
      data_out_q <= data_out_q;
    end
  end

  assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_queue_fifo.sv
// tb_queue_fifo: directed test-plan sequences followed by random push/pop/reset traffic,
// every cycle compared against a queue-based reference model.
module tb_queue_fifo;
  localparam int DEPTH = 8;
  localparam int WIDTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             push = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             full, empty, overflow, underflow;
  logic [CW-1:0]    count;

  int compared = 0;
  int mismatched = 0;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] exp_dout = '0;
  logic             exp_ovf = 1'b0;
  logic             exp_unf = 1'b0;

  queue_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rstN(rstN), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(model_q.size()));
    chk("full", 32'(full), 32'(model_q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(model_q.size() == 0));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_unf));
    chk("data_out", 32'(data_out), 32'(exp_dout));
  endtask

  // One clock: apply inputs, advance the model on the same edge, then compare.
  task automatic step(input logic rn, input logic p, input logic [WIDTH-1:0] d, input logic o);
    bit pop_ok, push_ok;
    rstN = rn; push = p; data_in = d; pop = o;
    @(posedge clk);
    if (!rn) begin
      model_q.delete();
      exp_dout = '0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      pop_ok  = o && (model_q.size() > 0);
      push_ok = p && ((model_q.size() < DEPTH) || pop_ok);
      exp_ovf = p && !push_ok;
      exp_unf = o && !pop_ok;
      if (pop_ok) begin
`ifdef QUEUE_FIFO_FWFT_EN
        void'(model_q.pop_front());
`else
        exp_dout = model_q.pop_front();
`endif
      end
      if (push_ok) model_q.push_back(d);
    end
`ifdef QUEUE_FIFO_FWFT_EN
    exp_dout = (model_q.size() > 0) ? model_q[0] : '0;
`endif
    #1;
    check_all();
  endtask

  initial begin
    int pb, ob;
    // Test 1: reset, three pushes, three pops
    step(1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 4'h1, 1'b0);
    step(1'b1, 1'b1, 4'h2, 1'b0);
    step(1'b1, 1'b1, 4'h3, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, 1'b1);
    chk("t1_end_empty", 32'(empty), 32'd1);
    // Test 2: fill, overflow, drain
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 4'(i), 1'b0);
    chk("t2_full", 32'(full), 32'd1);
    step(1'b1, 1'b1, 4'hA, 1'b0);
    chk("t2_ovf", 32'(overflow), 32'd1);
    step(1'b1, 1'b0, 4'h0, 1'b0);
    chk("t2_ovf_clear", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'h0, 1'b1);
    // Test 3: wrap-around
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'(i + 3), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 4'h9, 1'b0);
    step(1'b1, 1'b1, 4'hB, 1'b0);
    step(1'b1, 1'b1, 4'hC, 1'b0);
    step(1'b1, 1'b1, 4'hD, 1'b0);
    step(1'b1, 1'b1, 4'hE, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'h0, 1'b1);
    // Test 4: full with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 4'(i + 1), 1'b0);
    step(1'b1, 1'b1, 4'hF, 1'b1);
    chk("t4_count_full", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'h0, 1'b1);
`ifndef QUEUE_FIFO_FWFT_EN
    chk("t4_last_is_F", 32'(data_out), 32'hF);
`endif
    // Test 5: underflow alone, then push+pop on empty
    step(1'b1, 1'b0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 4'h5, 1'b1);
    chk("t5_count_one", 32'(count), 32'd1);
    step(1'b1, 1'b0, 4'h0, 1'b1);
    // Test 6: reset mid-stream overrides push
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'(i + 7), 1'b0);
    step(1'b0, 1'b1, 4'h6, 1'b0);
    chk("t6_count_reset", 32'(count), 32'd0);
    step(1'b1, 1'b0, 4'h0, 1'b1);
    // FWFT rerun of test 1 is covered by the model: data_out tracks the head each cycle
    step(1'b1, 1'b1, 4'h1, 1'b0);
    step(1'b1, 1'b1, 4'h2, 1'b0);
    step(1'b1, 1'b1, 4'h3, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, 1'b1);
    // Random traffic with alternating fill/drain bias and occasional reset
    for (int i = 0; i < 600; i++) begin
      pb = ((i / 100) % 2 == 0) ? 70 : 35;
      ob = ((i / 100) % 2 == 0) ? 35 : 70;
      step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
           ($urandom_range(0, 99) < pb) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < ob) ? 1'b1 : 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/queue_fifo.md
Name: queue_fifo

Overview:
Synchronous first-in/first-out buffer: the read-from-the-opposite-end companion to the team's LIFO stack block. Entries are written at the tail and read from the head.
One-hot write and read pointers, an occupancy counter, and full/empty flags.
Sits between producer and consumer stages in the lab datapaths: producer drives push, consumer drives pop.

Parameters:
DEPTH, 8, number of entries (>=2)
WIDTH, 4, bits per entry
CW, $clog2(DEPTH+1), width of count output (derived; not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rstN  input  1  synchronous active-low reset
push  input  1  write request; data_in captured at tail when accepted
data_in  input  WIDTH  write data
pop  input  1  read request; head entry removed when accepted
data_out  output  WIDTH  read data (registered; see Behaviour / Optional Feature)
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  CW  current occupancy 0..DEPTH
overflow  output  1  one-cycle pulse: push rejected
underflow  output  1  one-cycle pulse: pop rejected

Behaviour:
- Reset: rstN sampled low at a rising clk edge sets the following. Reset overrides push/pop in that cycle, including mid-stream; stored data is discarded.
  - All entries = 0.
  - wr_ptr = rd_ptr = one-hot bit 0.
  - count = 0, data_out = 0, overflow = 0, underflow = 0.
  - Hence empty = 1 and full = 0.
- Pointers: DEPTH-bit one-hot registers. On advance, rotate left by 1; bit DEPTH-1 wraps to bit 0. Exactly one bit set at all times.
- Storage: written at the entry selected by wr_ptr. Read selection is an OR-reduction of entries gated by rd_ptr (no binary decode).
- full and empty: combinational from count.
- Accept rules, evaluated on the pre-edge state:
  - pop_ok = pop && !empty
  - push_ok = push && (!full || pop_ok)
    - Full with simultaneous push and pop: both accepted; count stays DEPTH.
  - Empty with simultaneous push and pop: push accepted, pop rejected. underflow pulses and count becomes 1 (non-FWFT build).
- Count update: +1 if push_ok only; -1 if pop_ok only; unchanged if both or neither.
  - count never exceeds DEPTH and never goes below 0.
- Write: on push_ok, mem[wr_ptr] <= data_in and wr_ptr rotates.
- Read (default build):
  - On pop_ok, data_out <= mem[rd_ptr] and rd_ptr rotates. Data is visible one cycle after the pop edge.
  - data_out holds its value when no pop is accepted.
  - A pop and push to the same slot in one cycle cannot occur except when full; then the read returns the old entry.
- overflow <= push && !push_ok. underflow <= pop && !pop_ok.
  - Both are registered, high for exactly the one cycle following the offending request.
  - Both cleared by reset.
- Rejected requests change no state other than the pulse outputs.

Optional Feature:
Macro QUEUE_FIFO_FWFT_EN (first-word fall-through).
- Defined:
  - data_out is combinational mem[rd_ptr] whenever !empty, and 0 when empty.
  - pop acknowledges the currently shown word; the next head appears in the same cycle after the edge.
  - pop on empty still underflows. Push+pop on empty: push accepted, pop rejected.
  - Zero read latency.
- Undefined: registered one-cycle-latency read as in Behaviour.
- All other ports and flags are identical in both builds.

Test Plan:
1. Reset, then push 0x1,0x2,0x3 on consecutive cycles, then pop x3 -> data_out 0x1,0x2,0x3 each one cycle after its pop; count 3→0; empty=1 at end.
2. Fill with 0x0..0x7 (DEPTH=8) -> full=1 and count=8 after the 8th push. Push 0xA -> overflow pulses for 1 cycle, count stays 8. Pop x8 returns 0x0..0x7 (0xA never stored).
3. Wrap-around: push 6, pop 6, push 0x9,0xB,0xC,0xD,0xE -> pointers wrap past bit 7; pops return 0x9,0xB,0xC,0xD,0xE in order.
4. When full, assert push(0xF)+pop together -> pop returns the oldest entry, count stays 8, no overflow. After 7 further pops the next pop returns 0xF.
5. When empty: pop alone -> underflow pulse, data_out unchanged, count 0. Then push(0x5)+pop together -> underflow pulse, count 1, and a later pop returns 0x5.
6. Fill to count=5, assert rstN=0 for one cycle while push=1 -> count=0, empty=1, data_out=0, and a subsequent pop underflows. With QUEUE_FIFO_FWFT_EN, rerun test 1: data_out=0x1 in the cycle after the first push, before any pop.
